// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM word and status, plus the memory arbiter grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Free-running wrap-around grant and instruction-stall counters for the memory arbiter.
module arb_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             icomplete,
    input  logic             dcomplete,
    input  logic             istall,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] dgrant_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] igrant_cnt_q, igrant_cnt_d;
    logic [CNT_W-1:0] dgrant_cnt_q, dgrant_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        igrant_cnt_d = igrant_cnt_q + CNT_W'(icomplete);
        dgrant_cnt_d = dgrant_cnt_q + CNT_W'(dcomplete);
        stall_cnt_d  = stall_cnt_q + CNT_W'(istall);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrant_cnt_q <= '0;
            dgrant_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            igrant_cnt_q <= igrant_cnt_d;
            dgrant_cnt_q <= dgrant_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign igrant_cnt = igrant_cnt_q;
    assign dgrant_cnt = dgrant_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins unless the
// instruction side has waited STARVE_LIMIT data grants. ARB_PERF_EN adds perf counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  word_t            iaddr,
    output logic             iwait,
    output word_t            iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    output logic             dwait,
    output word_t            dload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate
`ifdef ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] dgrant_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          dreq;
    logic          icomplete;
    logic          dcomplete;

    assign dreq  = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

    // RAM strobes and waits are decoded from the registered grant so a withdrawn
    // request or an ACCESS response takes effect in the same cycle.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        icomplete    = 1'b0;
        dcomplete    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq && !(iREN && starve_cnt_q == STARVE_MAX)) state_d = DACC;
                else if (iREN)                                     state_d = IACC;
            end
            IACC: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN || ramstate == ERROR) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    icomplete = 1'b1;
                    iwait     = 1'b0;
                    state_d   = IDLE;
                end
            end
            DACC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq || ramstate == ERROR) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    dcomplete = 1'b1;
                    dwait     = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (icomplete) begin
            starve_cnt_d = '0;
        end else if (dcomplete) begin
            if (!iREN)                          starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef ARB_PERF_EN
    arb_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .CLK        (CLK),
        .nRST       (nRST),
        .icomplete  (icomplete),
        .dcomplete  (dcomplete),
        .istall     (iREN & iwait),
        .igrant_cnt (igrant_cnt),
        .dgrant_cnt (dgrant_cnt),
        .stall_cnt  (stall_cnt)
    );
`endif

endmodule
